// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT sample buffer controllers (read and write side).
// Holds the default geometry and the frame FSM state encoding.
package fft_buf_pkg;

   localparam int FFT_DATA_W   = 16;
   localparam int FFT_ADDR_W   = 12;
   localparam int FFT_N_POINTS = 4096;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/ram_rd_ctrl_if.sv
// RAM read port plus FFT-bound sample stream, grouped for the read-side controller.
// The master modport is the controller, the slave modport is the RAM/FFT side.
interface ram_rd_ctrl_if
   import fft_buf_pkg::*;
#(
   parameter int DATA_W = FFT_DATA_W,
   parameter int ADDR_W = FFT_ADDR_W
);

   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;

   modport master (
      output rd_en, rd_addr, m_tdata, m_tvalid, m_tlast,
      input  rd_data, m_tready
   );

   modport slave (
      input  rd_en, rd_addr, m_tdata, m_tvalid, m_tlast,
      output rd_data, m_tready
   );

endinterface

// File: rtl/ram_rd_ctrl_rd_skid_fifo.sv
// Two-entry skid FIFO holding RAM read data plus its frame-last tag.
// Head is presented straight from storage so the output stays stable while stalled.
module rd_skid_fifo #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wrPtr_q, wrPtr_d;
   logic             rdPtr_q, rdPtr_d;
   logic [1:0]       count_q, count_d;

   always_comb begin
      wrPtr_d = wrPtr_q ^ push_i;
      rdPtr_d = rdPtr_q ^ pop_i;
      count_d = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + 2'd1;
      end else if (!push_i && pop_i) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wrPtr_q  <= 1'b0;
         rdPtr_q  <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wrPtr_q] <= push_data_i;
         end
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rdPtr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ram_rd_ctrl.sv
// Read-side controller: on a frame_rdy rising edge streams N_POINTS RAM samples to the FFT.
// Optional sticky overrun flag for frame_rdy edges while busy: define RD_OVERRUN_DET_EN.
module ram_rd_ctrl
   import fft_buf_pkg::*;
#(
   parameter int DATA_W   = FFT_DATA_W,
   parameter int ADDR_W   = FFT_ADDR_W,
   parameter int N_POINTS = FFT_N_POINTS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_rdy_i,
   ram_rd_ctrl_if.master bus,
   output logic          busy_o,
   output logic          frame_done_o
`ifdef RD_OVERRUN_DET_EN
   ,
   output logic          overrun_o
`endif
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_POINTS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
   logic              frameRdy_q;
   logic              inFlight_q, inFlight_d;
   logic              inFlightLast_q, inFlightLast_d;
   logic              frameDone_q, frameDone_d;
   logic              start, rdEn, pop, popLast;
   logic [1:0]        fifoCount;
   logic [DATA_W:0]   fifoHead;
   logic [2:0]        slotsUsed;

   assign start   = frame_rdy_i & ~frameRdy_q;
   assign pop     = bus.m_tvalid & bus.m_tready;
   assign popLast = pop & bus.m_tlast;

   // A slot freed by this cycle's pop may be refilled, which keeps one sample per cycle.
   assign slotsUsed = 3'(fifoCount) + 3'(inFlight_q) - 3'(pop);

   always_comb begin
      state_d        = state_q;
      rdAddr_d       = rdAddr_q;
      rdEn           = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            rdAddr_d = '0;
            if (start) begin
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (slotsUsed < 3'd2) begin
               rdEn = 1'b1;
               if (rdAddr_q == LastAddr) begin
                  state_d = ST_DRAIN;
               end else begin
                  rdAddr_d = rdAddr_q + ADDR_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (popLast) begin
               state_d  = ST_IDLE;
               rdAddr_d = '0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            rdAddr_d = '0;
         end
      endcase
      inFlight_d     = rdEn;
      inFlightLast_d = rdEn & (rdAddr_q == LastAddr);
      frameDone_d    = popLast;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         rdAddr_q       <= '0;
         frameRdy_q     <= 1'b0;
         inFlight_q     <= 1'b0;
         inFlightLast_q <= 1'b0;
         frameDone_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         rdAddr_q       <= rdAddr_d;
         frameRdy_q     <= frame_rdy_i;
         inFlight_q     <= inFlight_d;
         inFlightLast_q <= inFlightLast_d;
         frameDone_q    <= frameDone_d;
      end
   end

   rd_skid_fifo #(
      .WIDTH(DATA_W + 1)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (inFlight_q),
      .push_data_i({inFlightLast_q, bus.rd_data}),
      .pop_i      (pop),
      .head_o     (fifoHead),
      .count_o    (fifoCount)
   );

   assign bus.rd_en    = rdEn;
   assign bus.rd_addr  = rdAddr_q;
   assign bus.m_tdata  = fifoHead[DATA_W-1:0];
   assign bus.m_tlast  = fifoHead[DATA_W];
   assign bus.m_tvalid = (fifoCount != 2'd0);
   assign busy_o       = (state_q != ST_IDLE);
   assign frame_done_o = frameDone_q;

`ifdef RD_OVERRUN_DET_EN
   logic overrun_q, overrun_d;

   assign overrun_d = overrun_q | (start & busy_o);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign overrun_o = overrun_q;
`endif

endmodule

// File: tb/tb_ram_rd_ctrl.sv
// Scoreboard bench for ram_rd_ctrl with a 16-point frame and a RAM model returning data = address.
// Build with RD_OVERRUN_DET_EN defined to also exercise the overrun flag.
module tb_ram_rd_ctrl;
   import fft_buf_pkg::*;

   localparam int DW = 16;
   localparam int AW = 12;
   localparam int NP = 16;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic clk       = 1'b0;
   logic rst_n     = 1'b1;
   logic frame_rdy = 1'b0;
   logic busy;
   logic frame_done;
`ifdef RD_OVERRUN_DET_EN
   logic overrun;
`endif

   int   vectors     = 0;
   int   miscompares = 0;
   int   cycleCnt    = 0;
   int   issued      = 0;
   int   handshakes  = 0;
   int   startCycle  = 0;
   exp_t expQ[$];

   ram_rd_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   ram_rd_ctrl #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .N_POINTS(NP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_rdy_i (frame_rdy),
      .bus         (bus),
      .busy_o      (busy),
      .frame_done_o(frame_done)
`ifdef RD_OVERRUN_DET_EN
      ,
      .overrun_o   (overrun)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Synchronous-read RAM: data equals address, valid one cycle after rd_en
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.rd_data <= DW'(bus.rd_addr);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Raise frame_rdy from low and queue the frame the DUT is expected to stream
   task automatic applyStimulus();
      @(posedge clk);
      #1 frame_rdy = 1'b0;
      @(posedge clk);
      #1 frame_rdy = 1'b1;
      startCycle = cycleCnt;
      for (int i = 0; i < NP; i++) begin
         expQ.push_back('{data: DW'(i), last: (i == NP - 1)});
      end
   endtask

   task automatic waitFrameEnd(input string name);
      int n = 0;
      while ((expQ.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(expQ.size() == 0 && !busy), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic waitHandshakes(input int base, input int target);
      int n = 0;
      while ((handshakes - base) < target && n < 300) begin
         @(posedge clk);
         n++;
      end
      checkOutput("wait_handshakes", 32'((handshakes - base) >= target), 32'd1);
   endtask

   // Monitor: pops the scoreboard on every handshake and checks stall stability and read gating
   logic          prevStall = 1'b0;
   logic [DW-1:0] prevData  = '0;
   logic          prevLast  = 1'b0;
   logic          doneDue   = 1'b0;
   always @(negedge clk) begin
      logic hs;
      exp_t e;
      if (!rst_n) begin
         issued     = 0;
         handshakes = 0;
         prevStall  = 1'b0;
         doneDue    = 1'b0;
      end else begin
         hs = bus.m_tvalid & bus.m_tready;
         if (prevStall) begin
            checkOutput("stall_valid", 32'(bus.m_tvalid), 32'd1);
            checkOutput("stall_data", 32'(bus.m_tdata), 32'(prevData));
            checkOutput("stall_last", 32'(bus.m_tlast), 32'(prevLast));
         end
         if (bus.rd_en) begin
            checkOutput("rd_gate_outstanding_lt2",
                        32'((issued - handshakes - (hs ? 1 : 0)) < 2), 32'd1);
            issued++;
         end
         if (doneDue || frame_done) begin
            checkOutput("frame_done_pulse", 32'(frame_done), 32'(doneDue));
            if (doneDue) checkOutput("busy_after_frame", 32'(busy), 32'd0);
         end
         doneDue = 1'b0;
         if (hs) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_sample", 32'(bus.m_tdata), 32'hFFFF_FFFF);
            end else begin
               e = expQ.pop_front();
               checkOutput("sample_data", 32'(bus.m_tdata), 32'(e.data));
               checkOutput("sample_last", 32'(bus.m_tlast), 32'(e.last));
            end
            handshakes++;
            doneDue = bus.m_tlast;
         end
         prevStall = bus.m_tvalid & ~bus.m_tready;
         prevData  = bus.m_tdata;
         prevLast  = bus.m_tlast;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int ipat;
      logic [3:0] readyPat;
      bus.m_tready = 1'b1;
      readyPat     = 4'b1001;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_rd_en", 32'(bus.rd_en), 32'd0);
      checkOutput("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
      checkOutput("reset_m_tvalid", 32'(bus.m_tvalid), 32'd0);
      checkOutput("reset_m_tlast", 32'(bus.m_tlast), 32'd0);
      checkOutput("reset_m_tdata", 32'(bus.m_tdata), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
`ifdef RD_OVERRUN_DET_EN
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
`endif
      rst_n = 1'b1;

      $display("[TB] test 1: full-rate frame");
      applyStimulus();
      @(negedge clk);
      checkOutput("t1_rd_en_cycle0", 32'(bus.rd_en), 32'd0);
      @(negedge clk);
      checkOutput("t1_rd_en_cycle1", 32'(bus.rd_en), 32'd1);
      checkOutput("t1_rd_addr_cycle1", 32'(bus.rd_addr), 32'd0);
      checkOutput("t1_busy_cycle1", 32'(busy), 32'd1);
      for (int n = 0; n < 40 && !frame_done; n++) @(negedge clk);
      checkOutput("t1_done_latency", 32'(cycleCnt - startCycle), 32'(NP + 3));
      waitFrameEnd("t1_frame_complete");

      $display("[TB] test 2: ready pattern 1,0,0,1");
      applyStimulus();
      ipat = 0;
      while ((expQ.size() != 0 || busy) && ipat < 300) begin
         @(posedge clk);
         #1 bus.m_tready = readyPat[3 - (ipat % 4)];
         ipat++;
      end
      bus.m_tready = 1'b1;
      waitFrameEnd("t2_frame_complete");

      $display("[TB] test 3: ready held low");
      bus.m_tready = 1'b0;
      base = issued;
      applyStimulus();
      repeat (20) @(negedge clk);
      checkOutput("t3_reads_issued", 32'(issued - base), 32'd2);
      checkOutput("t3_m_tvalid", 32'(bus.m_tvalid), 32'd1);
      checkOutput("t3_m_tdata", 32'(bus.m_tdata), 32'd0);
      @(posedge clk);
      #1 bus.m_tready = 1'b1;
      waitFrameEnd("t3_frame_complete");

      $display("[TB] test 4: frame_rdy held high");
      base = issued;
      repeat (30) @(negedge clk);
      checkOutput("t4_no_restart_busy", 32'(busy), 32'd0);
      checkOutput("t4_no_restart_reads", 32'(issued - base), 32'd0);
      applyStimulus();
      waitFrameEnd("t4_second_frame");

      $display("[TB] test 5: frame_rdy edge while busy");
      base = handshakes;
      applyStimulus();
      @(posedge clk);
      #1 frame_rdy = 1'b0;
      waitHandshakes(base, 7);
`ifdef RD_OVERRUN_DET_EN
      checkOutput("t5_overrun_before", 32'(overrun), 32'd0);
`endif
      #1 frame_rdy = 1'b1;
      @(posedge clk);
      #1 frame_rdy = 1'b0;
      waitFrameEnd("t5_frame_complete");
      checkOutput("t5_single_frame_samples", 32'(handshakes - base), 32'(NP));
`ifdef RD_OVERRUN_DET_EN
      checkOutput("t5_overrun_set", 32'(overrun), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("t5_overrun_sticky", 32'(overrun), 32'd1);
`endif

      $display("[TB] test 6: reset mid-frame");
      base = handshakes;
      applyStimulus();
      @(posedge clk);
      #1 frame_rdy = 1'b0;
      waitHandshakes(base, 9);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("t6_rd_en", 32'(bus.rd_en), 32'd0);
      checkOutput("t6_rd_addr", 32'(bus.rd_addr), 32'd0);
      checkOutput("t6_m_tvalid", 32'(bus.m_tvalid), 32'd0);
      checkOutput("t6_m_tlast", 32'(bus.m_tlast), 32'd0);
      checkOutput("t6_m_tdata", 32'(bus.m_tdata), 32'd0);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_frame_done", 32'(frame_done), 32'd0);
`ifdef RD_OVERRUN_DET_EN
      checkOutput("t6_overrun_cleared", 32'(overrun), 32'd0);
`endif
      expQ.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus();
      waitFrameEnd("t6_frame_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
